mips_ex_mdu: RTL and testbench

Iterative multiply/divide unit for the EX stage, sitting beside the single-cycle ALU, AGU and branch datapaths and owning the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO requests from ID/EX over a valid/ready handshake. It runs multi-cycle operations on a bit-serial datapath and back-pressures the pipeline while busy. Operand width is parametrised, so the same block serves 32-bit and wider cores.

---
 rtl/mips_ex_mdu_pkg.sv | 27 ++
 rtl/mips_ex_mdu_if.sv | 36 +++
 rtl/mips_ex_mdu_div.sv | 29 ++
 rtl/mips_ex_mdu.sv | 178 +++++++++++++++++
 tb/tb_mips_ex_mdu.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_ex_mdu_pkg.sv
// mips_ex_mdu_pkg: shared definitions for the EX-stage multiply/divide unit.
//   - MIPS_MDU_OP_WIDTH : width of the MDU operation code
//   - mdu_op_e          : MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO encodings (0..7)
//   - mdu_state_e       : MDU FSM state encodings
package mips_ex_mdu_pkg;

  localparam int MIPS_MDU_OP_WIDTH = 3;

  typedef enum logic [MIPS_MDU_OP_WIDTH-1:0] {
    MIPS_MDU_OP_MULT  = 3'd0,
    MIPS_MDU_OP_MULTU = 3'd1,
    MIPS_MDU_OP_DIV   = 3'd2,
    MIPS_MDU_OP_DIVU  = 3'd3,
    MIPS_MDU_OP_MFHI  = 3'd4,
    MIPS_MDU_OP_MFLO  = 3'd5,
    MIPS_MDU_OP_MTHI  = 3'd6,
    MIPS_MDU_OP_MTLO  = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_MUL  = 2'd1,
    MDU_DIV  = 2'd2,
    MDU_FIX  = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mips_ex_mdu_if.sv
// mips_ex_mdu_if: ID/EX <-> MDU request/response bundle.
//   master (ID/EX side) drives: id2ex_mdu_valid, id2ex_mdu_op, id2ex_rs,
//                               id2ex_rt, ex_flush
//   slave  (MDU side)   drives: id2ex_mdu_ready, mdu2ex_rvalid, mdu2ex_rdata,
//                               mdu2ex_busy, mdu2ex_unimpl, mdu_hi, mdu_lo
interface mips_ex_mdu_if #(
  parameter int DATA_W = 32
) ();
  import mips_ex_mdu_pkg::*;

  logic                         id2ex_mdu_valid;
  logic                         id2ex_mdu_ready;
  logic [MIPS_MDU_OP_WIDTH-1:0] id2ex_mdu_op;
  logic [DATA_W-1:0]            id2ex_rs;
  logic [DATA_W-1:0]            id2ex_rt;
  logic                         ex_flush;
  logic                         mdu2ex_rvalid;
  logic [DATA_W-1:0]            mdu2ex_rdata;
  logic                         mdu2ex_busy;
  logic                         mdu2ex_unimpl;
  logic [DATA_W-1:0]            mdu_hi;
  logic [DATA_W-1:0]            mdu_lo;

  modport master (
    output id2ex_mdu_valid, id2ex_mdu_op, id2ex_rs, id2ex_rt, ex_flush,
    input  id2ex_mdu_ready, mdu2ex_rvalid, mdu2ex_rdata, mdu2ex_busy,
           mdu2ex_unimpl, mdu_hi, mdu_lo
  );

  modport slave (
    input  id2ex_mdu_valid, id2ex_mdu_op, id2ex_rs, id2ex_rt, ex_flush,
    output id2ex_mdu_ready, mdu2ex_rvalid, mdu2ex_rdata, mdu2ex_busy,
           mdu2ex_unimpl, mdu_hi, mdu_lo
  );

endinterface

// File: rtl/mips_ex_mdu_div.sv
// mips_ex_mdu_div: one restoring-division iteration (combinational).
// Only instantiated when MIPS_MDU_DIV_EN is defined.
//   rem_i     : current partial remainder (always < divisor)
//   quo_i     : dividend bits still to consume (MSB first) / quotient so far
//   divisor_i : divisor magnitude
//   rem_o     : next partial remainder
//   quo_o     : quo_i shifted left with the new quotient bit in bit 0
module mips_ex_mdu_div #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quo_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quo_o
);

  logic [DATA_W:0]   shifted;
  logic [DATA_W+1:0] diff;

  assign shifted = {rem_i, quo_i[DATA_W-1]};
  assign diff    = {1'b0, shifted} - {2'b00, divisor_i};

  // A borrow (diff MSB set) means the divisor did not fit: restore.
  // Either way the surviving remainder is below the divisor, so DATA_W bits hold it.
  assign rem_o = diff[DATA_W+1] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
  assign quo_o = {quo_i[DATA_W-2:0], ~diff[DATA_W+1]};

endmodule

// File: rtl/mips_ex_mdu.sv
// mips_ex_mdu: iterative multiply/divide unit for the EX stage; owns HI/LO.
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : mips_ex_mdu_if.slave (request handshake, read data, status,
//                HI/LO trace outputs)
// Optional feature: define MIPS_MDU_DIV_EN to build the divider datapath and
// DIV state. Without it DIV/DIVU complete in IDLE, leave HI/LO alone and
// pulse mdu2ex_unimpl the cycle after accept.
module mips_ex_mdu
  import mips_ex_mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  mips_ex_mdu_if.slave bus
);

  localparam int               CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

  mdu_state_e          state_q, state_d;
  logic [DATA_W-1:0]   hi_q, lo_q, rdata_q, opnd_q;
  logic [2*DATA_W-1:0] acc_q;      // MUL: {partial sum, multiplier}; DIV: {remainder, quotient}
  logic [CNT_W-1:0]    cnt_q;
  logic                mul_q, neg_res_q, neg_rem_q, rvalid_q, unimpl_q;

  mdu_op_e           op;
  logic              accept, signed_op, rs_neg, rt_neg, last_iter;
  logic [DATA_W-1:0] rs_mag, rt_mag;

  assign op        = mdu_op_e'(bus.id2ex_mdu_op);
  assign accept    = bus.id2ex_mdu_valid && (state_q == MDU_IDLE) && !bus.ex_flush;
  assign signed_op = (op == MIPS_MDU_OP_MULT) || (op == MIPS_MDU_OP_DIV);
  assign rs_neg    = signed_op && bus.id2ex_rs[DATA_W-1];
  assign rt_neg    = signed_op && bus.id2ex_rt[DATA_W-1];
  // -(-2^(DATA_W-1)) wraps back to 2^(DATA_W-1), which is the correct unsigned magnitude.
  assign rs_mag    = rs_neg ? -bus.id2ex_rs : bus.id2ex_rs;
  assign rt_mag    = rt_neg ? -bus.id2ex_rt : bus.id2ex_rt;
  assign last_iter = (cnt_q == LAST_ITER);

  // Shift-add step; the carry out of the add becomes the new accumulator MSB.
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[DATA_W-1:1]}
                             : {1'b0, acc_q[2*DATA_W-1:1]};

`ifdef MIPS_MDU_DIV_EN
  logic [DATA_W-1:0] div_rem, div_quo;
  mips_ex_mdu_div #(.DATA_W(DATA_W)) u_div (
    .rem_i     (acc_q[2*DATA_W-1:DATA_W]),
    .quo_i     (acc_q[DATA_W-1:0]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .quo_o     (div_quo)
  );
`endif

  // Sign correction applied in FIX.
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quo_fix, rem_fix;
  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: begin
        if (accept) begin
          case (op)
            MIPS_MDU_OP_MULT, MIPS_MDU_OP_MULTU: state_d = MDU_MUL;
`ifdef MIPS_MDU_DIV_EN
            // Divide by zero skips iteration entirely.
            MIPS_MDU_OP_DIV, MIPS_MDU_OP_DIVU:
              state_d = (bus.id2ex_rt == '0) ? MDU_FIX : MDU_DIV;
`endif
            default: state_d = MDU_IDLE;
          endcase
        end
      end
      MDU_MUL, MDU_DIV: begin
        if (bus.ex_flush)  state_d = MDU_IDLE;
        else if (last_iter) state_d = MDU_FIX;
      end
      MDU_FIX: state_d = MDU_IDLE;
      default: state_d = MDU_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      rdata_q   <= '0;
      opnd_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      mul_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      rvalid_q  <= 1'b0;
      unimpl_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 1'b0;
      unimpl_q <= 1'b0;

      if (accept) begin
        cnt_q <= '0;
        case (op)
          MIPS_MDU_OP_MULT, MIPS_MDU_OP_MULTU: begin
            mul_q     <= 1'b1;
            opnd_q    <= rs_mag;
            acc_q     <= {{DATA_W{1'b0}}, rt_mag};
            neg_res_q <= rs_neg ^ rt_neg;
          end
          MIPS_MDU_OP_DIV, MIPS_MDU_OP_DIVU: begin
`ifdef MIPS_MDU_DIV_EN
            mul_q  <= 1'b0;
            opnd_q <= rt_mag;
            if (bus.id2ex_rt == '0) begin
              // Preload the final {HI,LO}; FIX passes it through uncorrected.
              acc_q     <= {bus.id2ex_rs, {DATA_W{1'b1}}};
              neg_res_q <= 1'b0;
              neg_rem_q <= 1'b0;
            end else begin
              acc_q     <= {{DATA_W{1'b0}}, rs_mag};
              neg_res_q <= rs_neg ^ rt_neg;
              neg_rem_q <= rs_neg;
            end
`else
            unimpl_q <= 1'b1;
`endif
          end
          MIPS_MDU_OP_MFHI: begin rdata_q <= hi_q; rvalid_q <= 1'b1; end
          MIPS_MDU_OP_MFLO: begin rdata_q <= lo_q; rvalid_q <= 1'b1; end
          MIPS_MDU_OP_MTHI: hi_q <= bus.id2ex_rs;
          MIPS_MDU_OP_MTLO: lo_q <= bus.id2ex_rs;
          default: ;
        endcase
      end

      if (state_q == MDU_MUL && !bus.ex_flush) begin
        acc_q <= mul_next;
        cnt_q <= cnt_q + CNT_W'(1);
      end

`ifdef MIPS_MDU_DIV_EN
      if (state_q == MDU_DIV && !bus.ex_flush) begin
        acc_q <= {div_rem, div_quo};
        cnt_q <= cnt_q + CNT_W'(1);
      end
`endif

      // A flush landing on FIX wins: HI/LO keep their old values.
      if (state_q == MDU_FIX && !bus.ex_flush) begin
        if (mul_q) begin
          hi_q <= prod_fix[2*DATA_W-1:DATA_W];
          lo_q <= prod_fix[DATA_W-1:0];
        end else begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end
      end
    end
  end

  assign bus.id2ex_mdu_ready = (state_q == MDU_IDLE);
  assign bus.mdu2ex_busy     = (state_q != MDU_IDLE);
  assign bus.mdu2ex_rvalid   = rvalid_q;
  assign bus.mdu2ex_rdata    = rdata_q;
  assign bus.mdu2ex_unimpl   = unimpl_q;
  assign bus.mdu_hi          = hi_q;
  assign bus.mdu_lo          = lo_q;

endmodule

// File: tb/tb_mips_ex_mdu.sv
// tb_mips_ex_mdu: directed self-checking bench for mips_ex_mdu (DATA_W = 32).
// Expectations for DIV/DIVU follow whether MIPS_MDU_DIV_EN is defined.
module tb_mips_ex_mdu;
  import mips_ex_mdu_pkg::*;

`ifdef MIPS_MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] cur_hi, cur_lo;

  mips_ex_mdu_if #(.DATA_W(32)) bus ();

  mips_ex_mdu #(.DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one request for exactly one cycle; returns at cycle 1.
  task automatic issue(input mdu_op_e op, input logic [31:0] rs, input logic [31:0] rt);
    bus.id2ex_mdu_valid = 1'b1;
    bus.id2ex_mdu_op    = op;
    bus.id2ex_rs        = rs;
    bus.id2ex_rt        = rt;
    chk1("ready_at_accept", bus.id2ex_mdu_ready, 1'b1);
    tick();
    bus.id2ex_mdu_valid = 1'b0;
  endtask

  // Issues an arithmetic op and checks busy/unimpl at cycle 1, ready cycle,
  // LO still old on the last busy cycle, and final HI/LO.
  task automatic do_op(input string tag, input mdu_op_e op, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] exp_hi,
                       input logic [31:0] exp_lo, input int exp_cyc,
                       input logic exp_busy, input logic exp_unimpl);
    logic [31:0] old_lo, lo_prev;
    int cyc;
    old_lo = bus.mdu_lo;
    issue(op, rs, rt);
    chk1({tag, "_busy1"}, bus.mdu2ex_busy, exp_busy);
    chk1({tag, "_unimpl1"}, bus.mdu2ex_unimpl, exp_unimpl);
    cyc = 1;
    lo_prev = bus.mdu_lo;
    while (!bus.id2ex_mdu_ready && cyc < 100) begin
      lo_prev = bus.mdu_lo;
      tick();
      cyc++;
    end
    chk({tag, "_ready_cycle"}, 32'(cyc), 32'(exp_cyc));
    chk({tag, "_lo_before_write"}, lo_prev, old_lo);
    chk({tag, "_hi"}, bus.mdu_hi, exp_hi);
    chk({tag, "_lo"}, bus.mdu_lo, exp_lo);
    $display("op %s rs=%h rt=%h -> hi=%h lo=%h ready@%0d", tag, rs, rt,
             bus.mdu_hi, bus.mdu_lo, cyc);
    cur_hi = exp_hi;
    cur_lo = exp_lo;
  endtask

  // Divide: full result when the divider is built, otherwise an unimpl pulse.
  task automatic do_div(input string tag, input mdu_op_e op, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [31:0] q_hi,
                        input logic [31:0] q_lo, input int q_cyc);
    do_op(tag, op, rs, rt,
          DIV_EN ? q_hi : cur_hi, DIV_EN ? q_lo : cur_lo,
          DIV_EN ? q_cyc : 1, DIV_EN, !DIV_EN);
  endtask

  task automatic read_chk(input string tag, input mdu_op_e op, input logic [31:0] exp);
    issue(op, 32'h0, 32'h0);
    chk1({tag, "_rvalid"}, bus.mdu2ex_rvalid, 1'b1);
    chk({tag, "_rdata"}, bus.mdu2ex_rdata, exp);
    $display("read %s rdata=%h", tag, bus.mdu2ex_rdata);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    bus.id2ex_mdu_valid = 1'b0;
    bus.id2ex_mdu_op    = MIPS_MDU_OP_MFHI;
    bus.id2ex_rs        = '0;
    bus.id2ex_rt        = '0;
    bus.ex_flush        = 1'b0;
    cur_hi = '0;
    cur_lo = '0;

    // Reset state
    #1;
    chk1("rst_ready", bus.id2ex_mdu_ready, 1'b1);
    chk1("rst_busy", bus.mdu2ex_busy, 1'b0);
    chk1("rst_rvalid", bus.mdu2ex_rvalid, 1'b0);
    chk1("rst_unimpl", bus.mdu2ex_unimpl, 1'b0);
    chk("rst_hi", bus.mdu_hi, 32'h0);
    chk("rst_lo", bus.mdu_lo, 32'h0);
    chk("rst_rdata", bus.mdu2ex_rdata, 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Multiplies
    do_op("mult_7_m3", MIPS_MDU_OP_MULT, 32'd7, 32'hFFFF_FFFD,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 34, 1'b1, 1'b0);
    do_op("multu_max", MIPS_MDU_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 34, 1'b1, 1'b0);
    do_op("mult_minneg", MIPS_MDU_OP_MULT, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 32'h0000_0000, 34, 1'b1, 1'b0);

    // Divides
    do_div("div_m21_4", MIPS_MDU_OP_DIV, 32'hFFFF_FFEB, 32'd4,
           32'hFFFF_FFFF, 32'hFFFF_FFFB, 34);
    do_div("div_min_m1", MIPS_MDU_OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h0000_0000, 32'h8000_0000, 34);
    do_div("div_7_m2", MIPS_MDU_OP_DIV, 32'd7, 32'hFFFF_FFFE,
           32'h0000_0001, 32'hFFFF_FFFD, 34);
    do_div("divu_100_7", MIPS_MDU_OP_DIVU, 32'd100, 32'd7,
           32'h0000_0002, 32'h0000_000E, 34);
    do_div("divu_5_0", MIPS_MDU_OP_DIVU, 32'd5, 32'd0,
           32'h0000_0005, 32'hFFFF_FFFF, 2);

    // MTLO visible to MFLO accepted at cycle 1; back-to-back reads
    issue(MIPS_MDU_OP_MTLO, 32'h0000_1234, 32'h0);
    read_chk("mflo_after_mtlo", MIPS_MDU_OP_MFLO, 32'h0000_1234);
    issue(MIPS_MDU_OP_MTHI, 32'hABCD_0001, 32'h0);
    bus.id2ex_mdu_valid = 1'b1;
    bus.id2ex_mdu_op    = MIPS_MDU_OP_MFHI;
    tick();
    chk1("b2b_mfhi_rvalid", bus.mdu2ex_rvalid, 1'b1);
    chk("b2b_mfhi_rdata", bus.mdu2ex_rdata, 32'hABCD_0001);
    bus.id2ex_mdu_op = MIPS_MDU_OP_MFLO;
    tick();
    bus.id2ex_mdu_valid = 1'b0;
    chk1("b2b_mflo_rvalid", bus.mdu2ex_rvalid, 1'b1);
    chk("b2b_mflo_rdata", bus.mdu2ex_rdata, 32'h0000_1234);
    tick();
    chk1("rvalid_single_pulse", bus.mdu2ex_rvalid, 1'b0);
    $display("read b2b hi=%h lo=%h", bus.mdu_hi, bus.mdu_lo);

    // MFLO held during MULT interlocks until result is written
    issue(MIPS_MDU_OP_MULT, 32'd3, 32'd4);
    bus.id2ex_mdu_valid = 1'b1;
    bus.id2ex_mdu_op    = MIPS_MDU_OP_MFLO;
    cyc = 1;
    while (!bus.id2ex_mdu_ready && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("interlock_ready_cycle", 32'(cyc), 32'd34);
    tick();
    bus.id2ex_mdu_valid = 1'b0;
    chk1("interlock_rvalid", bus.mdu2ex_rvalid, 1'b1);
    chk("interlock_rdata", bus.mdu2ex_rdata, 32'd12);
    chk("interlock_hi", bus.mdu_hi, 32'h0);
    $display("interlock mflo rdata=%h ready@%0d", bus.mdu2ex_rdata, cyc);

    // Same sequence with flush at cycle 10
    issue(MIPS_MDU_OP_MTLO, 32'h0000_1234, 32'h0);
    issue(MIPS_MDU_OP_MULT, 32'd3, 32'd4);
    bus.id2ex_mdu_valid = 1'b1;
    bus.id2ex_mdu_op    = MIPS_MDU_OP_MFLO;
    for (int i = 1; i < 10; i++) tick();
    chk1("flush_busy_c10", bus.mdu2ex_busy, 1'b1);
    bus.ex_flush = 1'b1;
    tick();
    bus.ex_flush = 1'b0;
    chk1("flush_ready_c11", bus.id2ex_mdu_ready, 1'b1);
    chk1("flush_busy_c11", bus.mdu2ex_busy, 1'b0);
    tick();
    bus.id2ex_mdu_valid = 1'b0;
    chk1("flush_mflo_rvalid", bus.mdu2ex_rvalid, 1'b1);
    chk("flush_mflo_rdata", bus.mdu2ex_rdata, 32'h0000_1234);
    $display("flush c10 mflo rdata=%h", bus.mdu2ex_rdata);

    // Flush coinciding with FIX (cycle 33) keeps HI/LO
    issue(MIPS_MDU_OP_MULT, 32'd5, 32'd5);
    for (int i = 1; i < 33; i++) tick();
    chk1("fixflush_busy_c33", bus.mdu2ex_busy, 1'b1);
    bus.ex_flush = 1'b1;
    tick();
    bus.ex_flush = 1'b0;
    chk1("fixflush_ready", bus.id2ex_mdu_ready, 1'b1);
    chk("fixflush_lo", bus.mdu_lo, 32'h0000_1234);
    chk("fixflush_hi", bus.mdu_hi, 32'h0);
    $display("flush at fix hi=%h lo=%h", bus.mdu_hi, bus.mdu_lo);

    // Flush in IDLE blocks acceptance
    bus.ex_flush        = 1'b1;
    bus.id2ex_mdu_valid = 1'b1;
    bus.id2ex_mdu_op    = MIPS_MDU_OP_MTLO;
    bus.id2ex_rs        = 32'hDEAD_BEEF;
    tick();
    bus.id2ex_mdu_op = MIPS_MDU_OP_MFHI;
    tick();
    bus.ex_flush        = 1'b0;
    bus.id2ex_mdu_valid = 1'b0;
    chk("idleflush_lo", bus.mdu_lo, 32'h0000_1234);
    chk1("idleflush_no_rvalid", bus.mdu2ex_rvalid, 1'b0);
    $display("flush in idle lo=%h rvalid=%b", bus.mdu_lo, bus.mdu2ex_rvalid);

    // Reset mid-operation
    issue(MIPS_MDU_OP_MULT, 32'd9, 32'd9);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    #1;
    chk1("midrst_busy", bus.mdu2ex_busy, 1'b0);
    chk1("midrst_ready", bus.id2ex_mdu_ready, 1'b1);
    chk("midrst_lo", bus.mdu_lo, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    read_chk("mflo_after_rst", MIPS_MDU_OP_MFLO, 32'h0);
    tick();
    chk1("after_rst_busy", bus.mdu2ex_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
